// File: rtl/ram_sdp_clr.sv
// ram_sdp_clr: simple-dual-port RAM with byte strobes, a hardware clear
// sequencer and a selectable read latency and read-during-write policy.
//
// After reset, every word is loaded with CLRVAL, one word per cycle.
// Writes use per-byte strobes.
// The read port is either combinational (RLAT=0) or registered (RLAT=1).
// For a registered read that hits the word being written, RDW selects
// whether rdata returns the old word or the merged new word.
module ram_sdp_clr #(
    parameter int             DW     = 32,
    parameter int             AW     = 6,
    parameter int             RLAT   = 0,
    parameter int             RDW    = 0,
    parameter logic [DW-1:0]  CLRVAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    input  logic              wen,
    input  logic [AW-1:0]     waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [DW/8-1:0]   wstrb,
    input  logic              ren,
    input  logic [AW-1:0]     raddr,
    output logic [DW-1:0]     rdata,
    output logic              rvalid
);

    localparam int SW    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    localparam logic [1:0] ST_RST   = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic [DW-1:0] mem_q [DEPTH];

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;

    // Sequencer: leave reset, sweep every address once, then serve users.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RST: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // Sequencer state register; reset can interrupt a clear at any point.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Busy also follows rst directly, so user accesses are blocked in the
    // same cycle reset is raised.
    assign busy = rst | (state_q != ST_READY);

    // Write-port mux: the clear sweep owns the port until READY.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        if (!rst && state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = CLRVAL;
            mem_wstrb = '1;
        end else if (!busy && wen) begin
            mem_we    = 1'b1;
        end
    end

    // Storage array, byte-granular write, no reset (the sweep initialises it).
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < SW; b++) begin
                if (mem_wstrb[b]) begin
                    mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    if (RLAT == 0) begin : g_async_read

        assign rdata  = mem_q[raddr];
        assign rvalid = ren & ~busy;

    end else begin : g_sync_read

        logic [DW-1:0] rdata_q, rdata_d;
        logic          rvalid_q, rvalid_d;
        logic [DW-1:0] merged_word;

        // Word as it will look after this cycle's user write lands.
        always_comb begin
            merged_word = mem_q[waddr];
            for (int b = 0; b < SW; b++) begin
                if (wstrb[b]) begin
                    merged_word[8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end

        // Read capture: a single-cycle valid per accepted read; the data holds otherwise.
        always_comb begin
            rdata_d  = rdata_q;
            rvalid_d = 1'b0;
            if (ren && !busy) begin
                rvalid_d = 1'b1;
                if (RDW != 0 && wen && waddr == raddr) begin
                    rdata_d = merged_word;
                end else begin
                    rdata_d = mem_q[raddr];
                end
            end
        end

        // Registered read outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rdata_q  <= rdata_d;
                rvalid_q <= rvalid_d;
            end
        end

        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;

    end

endmodule

// File: doc/ram_sdp_clr.md
Name: ram_sdp_clr

Overview:
- Parametrised simple-dual-port RAM: one write port, one read port, single clock.
- Successor to the single-port asynchronous-read RAM.
- Adds per-byte write strobes, selectable read latency (async or registered), a selectable read-during-write policy, and a hardware clear sequencer that initialises every word after reset.
- Used as register-file / scratchpad storage where known-clean contents after reset are required.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- AW, 6, address width; depth is 2**AW words.
- RLAT, 0, read latency: 0 = combinational read, 1 = registered read.
- RDW, 0, read-during-write policy when RLAT=1: 0 = read-first (old data), 1 = write-first (new merged data).
- CLRVAL, 0, DW-bit value written to every word during the clear sequence.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- busy  output  1  high while reset is asserted or the clear sequence runs.
- wen  input  1  write enable.
- waddr  input  AW  write address.
- wdata  input  DW  write data.
- wstrb  input  DW/8  byte write strobes; bit i covers wdata[8i+7:8i].
- ren  input  1  read enable.
- raddr  input  AW  read address.
- rdata  output  DW  read data.
- rvalid  output  1  rdata valid qualifier.

Behaviour:
- FSM states RST, CLEAR, READY; state and counter update on posedge clk.
- RST: entered at any edge with rst=1, from any state, including mid-CLEAR. Clear counter is set to 0. busy=1, rvalid=0, rdata register=0.
- RST->CLEAR: first edge with rst=0.
- CLEAR: each cycle writes CLRVAL (all bytes) to mem[counter], then counter+1. busy=1 throughout.
- CLEAR->READY: on the edge that writes address 2**AW-1. busy falls the cycle after that edge.
- Clear timing: exactly 2**AW cycles after rst deasserts, plus the RST-exit edge.
- READY: busy=0 and stays there until rst is asserted.
- While busy=1:
  - wen and ren are ignored; user writes are dropped and never queued.
  - rvalid=0.
  - RLAT=1: rdata register holds its value.
- Write in READY: on the edge with wen=1, mem[waddr] byte i <= wdata byte i for each wstrb[i]=1. Bytes with wstrb[i]=0 are unchanged. wstrb=0 with wen=1 is a no-op.
- RLAT=0:
  - rdata = mem[raddr] combinationally.
  - rvalid = ren & ~busy, combinational.
  - Same-address write: rdata shows old data until the write edge, new data after it.
- RLAT=1:
  - On an edge with ren=1 & ~busy, rdata <= mem[raddr]; rvalid <= 1 for one cycle per accepted read.
  - Otherwise rvalid <= 0 and rdata holds.
  - Back-to-back reads give back-to-back rvalid.
- Read-during-write, RLAT=1, raddr==waddr, wen=ren=1, same edge:
  - RDW=0: rdata gets the pre-write word.
  - RDW=1: rdata gets the merged word (strobed bytes from wdata, others from mem).
- Different addresses on the same edge are fully independent.
- Addresses cover the full 2**AW range; no out-of-range case exists.
- rdata reset value: 0 when RLAT=1. When RLAT=0, rdata is memory contents.

Test Plan:
1. Clear: DW=32, AW=4, CLRVAL=32'hA5A5A5A5. Hold rst 3 cycles, release.
   -> busy=1 for exactly 17 edges after release, then 0.
   -> Reads of all 16 addresses return A5A5A5A5.
2. Reset mid-clear: assert rst for 1 cycle at clear count 7, release.
   -> Counter restarts at 0; busy stays high a full 16 further cycles.
   -> All words read CLRVAL.
3. Byte strobes, RLAT=0: write addr 3 data 11223344 strobe 1111, then data AABBCCDD strobe 0101.
   -> Combinational read of addr 3 = 11BB33DD.
   -> rvalid follows ren.
4. RLAT=1 read-during-write: mem[5]=0. Same edge: write 5 data DEADBEEF strobe 1111, read 5.
   -> RDW=0: next-cycle rdata=00000000, rvalid=1.
   -> RDW=1: next-cycle rdata=DEADBEEF, rvalid=1.
5. Busy gating: wen=1 addr 2 data 12345678 and ren=1 during CLEAR.
   -> rvalid stays 0.
   -> After READY, addr 2 reads CLRVAL.
6. RLAT=1 streaming: reads of addr 0..15 on consecutive cycles after preloading mem[i]=i.
   -> rvalid high 16 consecutive cycles; rdata 0..15 in order, each one cycle after its raddr.
